// File: rtl/avalon_window_bridge.sv
// Bridges the HPS acknowledge-handshake bus onto 2**WIN_SEL_W local slave windows.
// Every upstream request completes exactly once, either normally or via error/timeout.
module avalon_window_bridge #(
   parameter int ADDR_W    = 24,
   parameter int DATA_W    = 32,
   parameter int WIN_SEL_W = 2,
   parameter int TIMEOUT   = 255,
   parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF,
   localparam int NUM_WIN  = 2**WIN_SEL_W
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic [ADDR_W-1:0]             avl_address,
   input  logic [DATA_W/8-1:0]           avl_byte_enable,
   input  logic                          avl_read,
   input  logic                          avl_write,
   input  logic [DATA_W-1:0]             avl_write_data,
   output logic                          avl_acknowledge,
   output logic [DATA_W-1:0]             avl_read_data,
   input  logic [NUM_WIN-1:0]            win_enable,
   output logic [NUM_WIN-1:0]            loc_sel,
   output logic [ADDR_W-WIN_SEL_W-1:0]   loc_addr,
   output logic [DATA_W/8-1:0]           loc_byte_enable,
   output logic                          loc_read,
   output logic                          loc_write,
   output logic [DATA_W-1:0]             loc_write_data,
   input  logic [DATA_W-1:0]             loc_read_data,
   input  logic                          loc_ready,
   output logic [7:0]                    err_count,
   output logic [ADDR_W-1:0]             err_addr
);

   localparam int BE_W  = DATA_W / 8;
   localparam int OFF_W = ADDR_W - WIN_SEL_W;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, ACK, HOLD} state_t;

   state_t                 state, state_next;
   logic [ADDR_W-1:0]      addr_q;
   logic [BE_W-1:0]        be_q;
   logic [DATA_W-1:0]      wdata_q;
   logic [DATA_W-1:0]      rdata_q;
   logic                   write_q;
   logic                   err_q;
   logic [WIN_SEL_W-1:0]   win_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [7:0]             err_count_q;
   logic [ADDR_W-1:0]      err_addr_q;

   logic                   load;
   logic                   start_err;
   logic                   timeout_err;
   logic                   capture;
   logic [WIN_SEL_W-1:0]   win_idx;

   assign win_idx = avl_address[ADDR_W-1 -: WIN_SEL_W];

   always_comb begin
      state_next  = state;
      load        = 1'b0;
      start_err   = 1'b0;
      timeout_err = 1'b0;
      capture     = 1'b0;
      unique case (state)
         IDLE: begin
            if (avl_read || avl_write) begin
               load = 1'b1;
               // Both strobes at once, or a disabled window, completes as an error without touching the slave.
               if ((avl_read && avl_write) || !win_enable[win_idx]) begin
                  start_err  = 1'b1;
                  state_next = ACK;
               end else begin
                  state_next = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (loc_ready) begin
               capture    = !write_q;
               state_next = ACK;
            end else if (cnt_q == CNT_LAST) begin
               timeout_err = 1'b1;
               state_next  = ACK;
            end
         end
         ACK:  state_next = HOLD;
         HOLD: begin
            if (!avl_read && !avl_write) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state       <= IDLE;
         addr_q      <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         write_q     <= 1'b0;
         err_q       <= 1'b0;
         win_q       <= '0;
         cnt_q       <= '0;
         err_count_q <= '0;
         err_addr_q  <= '0;
      end else begin
         state <= state_next;
         if (load) begin
            addr_q  <= avl_address;
            be_q    <= avl_byte_enable;
            wdata_q <= avl_write_data;
            write_q <= avl_write && !avl_read;
            win_q   <= win_idx;
            err_q   <= start_err;
         end
         if (timeout_err) err_q <= 1'b1;
         if (capture) rdata_q <= loc_read_data;
         cnt_q <= (state == ACCESS) ? cnt_q + 1'b1 : '0;
         // Error bookkeeping happens once, in the single acknowledge cycle; the count saturates.
         if (state == ACK && err_q) begin
            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            err_addr_q <= addr_q;
         end
      end
   end

   assign avl_acknowledge = (state == ACK);
   assign avl_read_data   = (state == ACK && !write_q) ? (err_q ? ERR_DATA : rdata_q) : '0;
   assign loc_sel         = (state == ACCESS) ? (NUM_WIN'(1) << win_q) : '0;
   assign loc_read        = (state == ACCESS) && !write_q;
   assign loc_write       = (state == ACCESS) && write_q;
   assign loc_addr        = addr_q[OFF_W-1:0];
   assign loc_byte_enable = be_q;
   assign loc_write_data  = wdata_q;
   assign err_count       = err_count_q;
   assign err_addr        = err_addr_q;

endmodule

// File: tb/tb_avalon_window_bridge.sv
// Scoreboard bench for avalon_window_bridge: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever the bridge acknowledges.
module tb_avalon_window_bridge;

   localparam int ADDR_W    = 24;
   localparam int DATA_W    = 32;
   localparam int WIN_SEL_W = 2;
   localparam int NUM_WIN   = 4;
   localparam int TIMEOUT   = 8;

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic [23:0]   avl_address = '0;
   logic [3:0]    avl_byte_enable = '0;
   logic          avl_read = 1'b0;
   logic          avl_write = 1'b0;
   logic [31:0]   avl_write_data = '0;
   logic          avl_acknowledge;
   logic [31:0]   avl_read_data;
   logic [3:0]    win_enable = 4'hF;
   logic [3:0]    loc_sel;
   logic [21:0]   loc_addr;
   logic [3:0]    loc_byte_enable;
   logic          loc_read;
   logic          loc_write;
   logic [31:0]   loc_write_data;
   logic [31:0]   loc_read_data = '0;
   logic          loc_ready = 1'b0;
   logic [7:0]    err_count;
   logic [23:0]   err_addr;

   avalon_window_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WIN_SEL_W(WIN_SEL_W),
      .TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEADBEEF)
   ) dut (
      .clock(clock), .resetn(resetn),
      .avl_address(avl_address), .avl_byte_enable(avl_byte_enable),
      .avl_read(avl_read), .avl_write(avl_write), .avl_write_data(avl_write_data),
      .avl_acknowledge(avl_acknowledge), .avl_read_data(avl_read_data),
      .win_enable(win_enable), .loc_sel(loc_sel), .loc_addr(loc_addr),
      .loc_byte_enable(loc_byte_enable), .loc_read(loc_read), .loc_write(loc_write),
      .loc_write_data(loc_write_data), .loc_read_data(loc_read_data),
      .loc_ready(loc_ready), .err_count(err_count), .err_addr(err_addr)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] data;
      int          latency;
      int          strobes;
      logic [63:0] fields;
      int          issue;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          ready_cfg = 0;
   int          sn = 0;
   int          cur_strobe = 0;
   logic [63:0] snap = '0;
   logic [63:0] cur_fields;

   assign cur_fields = {loc_sel, loc_addr, loc_byte_enable, loc_write_data, loc_read, loc_write};

   always @(posedge clock) cyc <= cyc + 1;

   // Local slave: raises ready on the ready_cfg-th strobe cycle (0 means never).
   always begin
      @(posedge clock);
      #2;
      if (loc_read || loc_write) sn = sn + 1;
      else sn = 0;
      loc_ready = (loc_read || loc_write) && (ready_cfg != 0) && (sn >= ready_cfg);
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] fieldsOf(input logic [3:0] sel, input logic [21:0] off,
                                           input logic [3:0] be, input logic [31:0] wd,
                                           input logic wr);
      return {sel, off, be, wd, ~wr, wr};
   endfunction

   // Monitor: strobe field checks, stability, and scoreboard pop on acknowledge.
   always @(negedge clock) begin
      exp_t e;
      if (!resetn) begin
         cur_strobe = 0;
      end else begin
         if (loc_read || loc_write) begin
            if (cur_strobe == 0) begin
               snap = cur_fields;
               if (sb.size() > 0) checkOutput("strobe_fields", cur_fields, sb[0].fields);
            end else begin
               checkOutput("strobe_stable", cur_fields, snap);
            end
            cur_strobe++;
         end
         if (avl_acknowledge) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_ack: got ack with data %0h expected no ack", avl_read_data);
            end else begin
               e = sb.pop_front();
               checkOutput("ack_data", 64'(avl_read_data), 64'(e.data));
               checkOutput("ack_latency", 64'(cyc - e.issue), 64'(e.latency));
               checkOutput("strobe_cycles", 64'(cur_strobe), 64'(e.strobes));
            end
            cur_strobe = 0;
         end else begin
            checkOutput("idle_read_data", 64'(avl_read_data), 64'd0);
         end
      end
   end

   task automatic applyStimulus(input logic rd, input logic wr, input logic [23:0] addr,
                                input logic [3:0] be, input logic [31:0] wd, input int ready_at,
                                input logic [31:0] exp_data, input int exp_strobes,
                                input logic [3:0] exp_sel);
      exp_t e;
      @(posedge clock);
      #1;
      e.data    = exp_data;
      e.strobes = exp_strobes;
      e.latency = exp_strobes + 1;
      e.fields  = fieldsOf(exp_sel, addr[21:0], be, wd, wr & ~rd);
      e.issue   = cyc;
      sb.push_back(e);
      ready_cfg       = ready_at;
      avl_address     = addr;
      avl_byte_enable = be;
      avl_write_data  = wd;
      avl_read        = rd;
      avl_write       = wr;
   endtask

   task automatic finishTxn(input int hold_extra);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clock);
         if (avl_acknowledge) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("[TB] FAIL ack_wait: got no ack within 60 cycles expected ack");
      end
      repeat (hold_extra) @(posedge clock);
      @(posedge clock);
      #1;
      avl_read  = 1'b0;
      avl_write = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ack"}, 64'(avl_acknowledge), 64'd0);
      checkOutput({tag, "_rdata"}, 64'(avl_read_data), 64'd0);
      checkOutput({tag, "_loc_fields"}, cur_fields, 64'd0);
      checkOutput({tag, "_err_count"}, 64'(err_count), 64'd0);
      checkOutput({tag, "_err_addr"}, 64'(err_addr), 64'd0);
   endtask

   initial begin
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkAllZero("reset");
      @(posedge clock);
      #1;
      resetn = 1'b1;

      // Zero-wait read, window 1
      loc_read_data = 32'h12345678;
      applyStimulus(1'b1, 1'b0, 24'h400010, 4'hF, 32'h0, 1, 32'h12345678, 1, 4'b0010);
      finishTxn(0);
      checkOutput("zero_wait_err_count", 64'(err_count), 64'd0);

      // Write with 5 wait cycles to window 3, request held two extra cycles
      applyStimulus(1'b0, 1'b1, 24'hC00040, 4'b0011, 32'hCAFEF00D, 5, 32'h0, 5, 4'b1000);
      finishTxn(2);
      checkOutput("wait_err_count", 64'(err_count), 64'd0);

      // Ready on the TIMEOUT-th cycle: normal completion
      loc_read_data = 32'h0A5A5A5A;
      applyStimulus(1'b1, 1'b0, 24'h000100, 4'hF, 32'h0, TIMEOUT, 32'h0A5A5A5A, TIMEOUT, 4'b0001);
      finishTxn(0);
      checkOutput("simul_err_count", 64'(err_count), 64'd0);

      // Timeout read, window 2
      applyStimulus(1'b1, 1'b0, 24'h8000A0, 4'hF, 32'h0, 0, 32'hDEADBEEF, TIMEOUT, 4'b0100);
      finishTxn(0);
      checkOutput("timeout_err_count", 64'(err_count), 64'd1);
      checkOutput("timeout_err_addr", 64'(err_addr), 64'h8000A0);

      // Disabled window 0
      win_enable = 4'b1110;
      applyStimulus(1'b1, 1'b0, 24'h000020, 4'hF, 32'h0, 1, 32'hDEADBEEF, 0, 4'b0001);
      finishTxn(0);
      checkOutput("disabled_err_count", 64'(err_count), 64'd2);
      checkOutput("disabled_err_addr", 64'(err_addr), 64'h000020);

      // Illegal read+write
      win_enable = 4'hF;
      applyStimulus(1'b1, 1'b1, 24'h400004, 4'hF, 32'h11112222, 1, 32'hDEADBEEF, 0, 4'b0010);
      finishTxn(0);
      checkOutput("illegal_err_count", 64'(err_count), 64'd3);
      checkOutput("illegal_err_addr", 64'(err_addr), 64'h400004);

      // Saturation: 300 more errors
      win_enable = 4'b1110;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 1'b0, 24'(i * 4), 4'hF, 32'h0, 1, 32'hDEADBEEF, 0, 4'b0001);
         finishTxn(0);
         if (i == 251) checkOutput("sat_reach_255", 64'(err_count), 64'd255);
      end
      checkOutput("sat_hold_255", 64'(err_count), 64'd255);
      checkOutput("sat_err_addr", 64'(err_addr), 64'h0004AC);

      // Reset during a wait state, request stays held and restarts
      win_enable    = 4'hF;
      loc_read_data = 32'h12345678;
      @(posedge clock);
      #1;
      ready_cfg       = 0;
      avl_address     = 24'h400010;
      avl_byte_enable = 4'hF;
      avl_write_data  = 32'h0;
      avl_read        = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      checkOutput("pre_reset_strobe", 64'(loc_read), 64'd1);
      resetn = 1'b0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
      begin
         exp_t e;
         e.data    = 32'h12345678;
         e.strobes = 2;
         e.latency = 3;
         e.fields  = fieldsOf(4'b0010, 22'h000010, 4'hF, 32'h0, 1'b0);
         e.issue   = cyc;
         sb.push_back(e);
         ready_cfg = 2;
      end
      @(negedge clock);
      checkAllZero("mid_reset");
      finishTxn(0);
      checkOutput("post_reset_err_count", 64'(err_count), 64'd0);

      repeat (3) @(posedge clock);
      checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
